id_stage_p: RTL and testbench
=============================

# id_stage_p

Parametrised instruction-decode stage with an integrated ID/EX pipeline register, generalised operand forwarding and load-use interlock. It sits between the IF/ID register and the EX stage. It decodes the MIPS32 logic, shift and arithmetic subset plus `lw`, selects operands from N prioritised forwarding sources, and holds a registered result under a valid/ready handshake. Stall and flush are handled internally.

## Interface
- `DATA_W`, 32, operand/result width
- `REG_AW`, 5, register address width
- `NUM_FWD`, 2, forwarding sources; index 0 = EX (highest priority), 1 = MEM, …
- `ALUOP_W`, 8, aluop width
- `ALUSEL_W`, 3, alusel width

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-low.
- `in_valid` in 1: IF/ID holds a valid instruction.
- `in_ready` out 1: the stage accepts the instruction this cycle.
- `pc_i` in 32: PC of the instruction.
- `inst_i` in 32: instruction word.
- `reg1_addr_o`, `reg2_addr_o` out REG_AW: regfile read addresses (combinational).
- `reg1_read_o`, `reg2_read_o` out 1: regfile read enables (combinational).
- `reg1_data_i`, `reg2_data_i` in DATA_W: regfile read data, same cycle.
- `fwd_wreg_i` in NUM_FWD: per-source write enable.
- `fwd_wd_i` in NUM_FWD*REG_AW: per-source destination register.
- `fwd_wdata_i` in NUM_FWD*DATA_W: per-source result.
- `ex_load_i` in 1: source 0 is a load, so its data is not yet valid.
- `flush_i` in 1: discard the held and incoming instruction.
- `out_valid` out 1: the ID/EX register holds a valid instruction.
- `out_ready` in 1: EX consumes the held instruction.
- `ex_pc_o` out 32: registered PC.
- `ex_aluop_o` out ALUOP_W: registered aluop.
- `ex_alusel_o` out ALUSEL_W: registered alusel.
- `ex_reg1_o`, `ex_reg2_o` out DATA_W: registered operands.
- `ex_wd_o` out REG_AW: registered destination register.
- `ex_wreg_o` out 1: registered write enable.
- `ex_is_load_o` out 1: registered load flag.
- `ex_instinvalid_o` out 1: registered reserved-instruction flag.
- `stall_o` out 1: load-use interlock is active (combinational).

## Operation
Decode is combinational from `inst_i`.
- Logic ops `or`/`and`/`xor`/`nor`/`ori`/`andi`/`xori`/`lui`: logic-immediates and `lui` use a zero-extended immediate (`lui` puts it in bits [31:16]).
- Shifts `sll`/`srl`/`sra`: `sa` goes into imm[4:0], only rt is read.
- Variable shifts `sllv`/`srlv`/`srav`: both registers are read.
- Arithmetic `add`/`addu`/`sub`/`subu`/`slt`/`sltu`, and `addi`/`addiu`/`slti`/`sltiu`: immediate forms use a sign-extended immediate.
- `lw`: sign-extended offset in `reg2`, destination rt, `is_load`=1.
- `sync`, `pref`, `sll $0,$0,0`: decode to a NOP with `wreg`=0.
- Any other encoding: NOP with `instinvalid`=1 and `wreg`=0.

Destination is rd for R-type and rt for I-type.

Operand selection, per port:
- Read disabled → imm.
- Address 0 → 0; address 0 is never forwarded.
- Otherwise the lowest-index source i with `fwd_wreg_i[i]` set and `fwd_wd_i[i]`==addr wins.
- No source matches → regfile data.

Hazard rule: `stall_o` = `in_valid` & `ex_load_i` & `fwd_wreg_i[0]` & (an enabled read port has a non-zero address equal to `fwd_wd_i[0]`).

Handshake:
- `in_ready` = !`stall_o` & (!`out_valid` | `out_ready`).
- A transfer occurs when `in_valid` & `in_ready`.

ID/EX register update, per cycle, in priority order:
1. `rst`=0 → all `ex_*` outputs are 0 and `out_valid`=0.
2. `flush_i` → `out_valid`=0 and `ex_wreg_o`=0; the incoming instruction is dropped and `in_ready` is ignored.
3. Transfer → load the decoded fields; `out_valid`=1.
4. `out_ready` & !transfer → `out_valid`=0 and `ex_wreg_o`=0. This is a bubble, e.g. during a stall.
5. Otherwise → hold all fields.

## Timing
- Decode-to-EX latency is 1 cycle: fields accepted at edge k appear on `ex_*` after edge k.
- `reg*_addr_o`, `reg*_read_o`, `stall_o` and `in_ready` are combinational from the same-cycle inputs.
- The load-use stall lasts exactly one cycle once EX advances. The next cycle, the load is in MEM (source 1) and forwarding resolves the operand.
- `flush_i` together with `in_valid`: nothing is accepted, and `out_valid`=0 next cycle.
- `rst` low mid-stream: the held instruction is lost and `out_valid`=0 on the next edge.
- `ex_pc_o` is a registered copy of `pc_i`.

## Structure
- The shared include `define.v` holds:
  - opcode/funct constants, including the new `EXE_ADD*`, `EXE_SUB*`, `EXE_SLT*` and `EXE_LW`;
  - aluop codes and alusel codes (`EXE_RES_ARITH`, `EXE_RES_LOAD_STORE` added);
  - the reset polarity constant.
- Sub-module `id_decode`: purely combinational. Maps `inst_i` to aluop, alusel, read enables/addresses, imm, wd, wreg, `is_load` and `instinvalid`.
- The top level holds the parametrised forwarding mux (a generate loop over NUM_FWD), the hazard logic, the handshake and the ID/EX register.

## Test plan
- Check reset: drive `rst`=0 for 2 cycles → `out_valid`=0, `ex_*`=0, `in_ready`=0 whenever `stall_o`=1.
- Check immediate extension: `ori $1,$0,0x8001` → `ex_reg1_o`=0, `ex_reg2_o`=0x00008001, `ex_wd_o`=1. Then `addi $2,$0,0x8001` → `ex_reg2_o`=0xFFFF8001.
- Check forwarding priority: `or $3,$1,$2` with fwd0=($1,0xAAAA) and fwd1=($1,0x5555) → `ex_reg1_o`=0xAAAA. With only fwd1 matching → 0x5555.
- Check $zero: `addu $4,$0,$0` with fwd0=($0,0xDEAD) → both operands 0.
- Check load-use: `lw $5` in EX (`ex_load_i`=1, fwd0=$5), then `add $6,$5,$5`:
  - the first cycle gives `stall_o`=1, `in_ready`=0 and a bubble (`out_valid`=0);
  - the next cycle gives the operand from fwd1 and `out_valid`=1.
- Check backpressure and flush: hold `out_ready`=0 for 3 cycles → `ex_*` stable and `in_ready`=0. Then `flush_i`=1 → `out_valid`=0 next cycle.

Source files
------------

// File: rtl/id_stage_p_pkg.sv
// id_stage_p_pkg: MIPS32 opcode/funct, aluop and alusel codes shared by the decode stage
package id_stage_p_pkg;
  localparam logic RST_ACTIVE = 1'b0;
  localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;
  localparam logic [5:0] EXE_ANDI = 6'b001100;
  localparam logic [5:0] EXE_ORI = 6'b001101;
  localparam logic [5:0] EXE_XORI = 6'b001110;
  localparam logic [5:0] EXE_LUI = 6'b001111;
  localparam logic [5:0] EXE_ADDI = 6'b001000;
  localparam logic [5:0] EXE_ADDIU = 6'b001001;
  localparam logic [5:0] EXE_SLTI = 6'b001010;
  localparam logic [5:0] EXE_SLTIU = 6'b001011;
  localparam logic [5:0] EXE_LW = 6'b100011;
  localparam logic [5:0] EXE_PREF = 6'b110011;
  localparam logic [5:0] EXE_SLL = 6'b000000;
  localparam logic [5:0] EXE_SRL = 6'b000010;
  localparam logic [5:0] EXE_SRA = 6'b000011;
  localparam logic [5:0] EXE_SLLV = 6'b000100;
  localparam logic [5:0] EXE_SRLV = 6'b000110;
  localparam logic [5:0] EXE_SRAV = 6'b000111;
  localparam logic [5:0] EXE_SYNC = 6'b001111;
  localparam logic [5:0] EXE_ADD = 6'b100000;
  localparam logic [5:0] EXE_ADDU = 6'b100001;
  localparam logic [5:0] EXE_SUB = 6'b100010;
  localparam logic [5:0] EXE_SUBU = 6'b100011;
  localparam logic [5:0] EXE_AND = 6'b100100;
  localparam logic [5:0] EXE_OR = 6'b100101;
  localparam logic [5:0] EXE_XOR = 6'b100110;
  localparam logic [5:0] EXE_NOR = 6'b100111;
  localparam logic [5:0] EXE_SLT = 6'b101010;
  localparam logic [5:0] EXE_SLTU = 6'b101011;
  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
  localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
  localparam logic [7:0] EXE_SLT_OP = 8'b00101010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b00101011;
  localparam logic [7:0] EXE_ADDI_OP = 8'b01010101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [7:0] EXE_LW_OP = 8'b11100011;
  typedef enum logic [2:0] {
    EXE_RES_NOP        = 3'b000,
    EXE_RES_LOGIC      = 3'b001,
    EXE_RES_SHIFT      = 3'b010,
    EXE_RES_ARITH      = 3'b100,
    EXE_RES_LOAD_STORE = 3'b111
  } alusel_e;
  // R-type aluops equal {2'b00, funct} except sll, whose funct is all zeros
  function automatic logic [7:0] r_aluop(input logic [5:0] fn);
    return fn == EXE_SLL ? EXE_SLL_OP : {2'b00, fn};
  endfunction
endpackage

// File: rtl/id_stage_p_if.sv
// id_stage_p_if: ID/EX register bus with valid/ready handshake towards EX
interface id_stage_p_if #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
);
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         ex_pc;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [ALUSEL_W-1:0] ex_alusel;
  logic [DATA_W-1:0]   ex_reg1;
  logic [DATA_W-1:0]   ex_reg2;
  logic [REG_AW-1:0]   ex_wd;
  logic                ex_wreg;
  logic                ex_is_load;
  logic                ex_instinvalid;
  modport master (output out_valid, ex_pc, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd,
                  ex_wreg, ex_is_load, ex_instinvalid, input out_ready);
  modport slave (input out_valid, ex_pc, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd,
                 ex_wreg, ex_is_load, ex_instinvalid, output out_ready);
endinterface

// File: rtl/id_stage_p_decode.sv
// id_decode: combinational MIPS32 logic/shift/arith/lw decoder
module id_decode
  import id_stage_p_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic [31:0]         inst_i,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  output logic [DATA_W-1:0]   imm_o,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic                is_load_o,
  output logic                instinvalid_o
);
  logic [5:0]  op, fn;
  logic [15:0] i16;
  logic [7:0]  aop;
  alusel_e     sel;
  logic [31:0] imm;
  logic        rt_dst;
  assign op = inst_i[31:26];
  assign fn = inst_i[5:0];
  assign i16 = inst_i[15:0];
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);
  assign wd_o = rt_dst ? REG_AW'(inst_i[20:16]) : REG_AW'(inst_i[15:11]);
  assign aluop_o = ALUOP_W'(aop);
  assign alusel_o = ALUSEL_W'(sel);
  assign imm_o = DATA_W'(imm);
  // Decode opcode/funct into control fields; unknown encodings stay NOP with instinvalid set
  always_comb begin
    aop = EXE_NOP_OP;
    sel = EXE_RES_NOP;
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    imm = '0;
    wreg_o = 1'b0;
    rt_dst = 1'b0;
    is_load_o = 1'b0;
    instinvalid_o = 1'b1;
    case (op)
      EXE_SPECIAL_INST:
        case (fn)
          EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
            aop = r_aluop(fn);
            sel = EXE_RES_LOGIC;
            {reg1_read_o, reg2_read_o, wreg_o, instinvalid_o} = 4'b1110;
          end
          EXE_SLLV, EXE_SRLV, EXE_SRAV: begin
            aop = r_aluop(fn);
            sel = EXE_RES_SHIFT;
            {reg1_read_o, reg2_read_o, wreg_o, instinvalid_o} = 4'b1110;
          end
          EXE_ADD, EXE_ADDU, EXE_SUB, EXE_SUBU, EXE_SLT, EXE_SLTU: begin
            aop = r_aluop(fn);
            sel = EXE_RES_ARITH;
            {reg1_read_o, reg2_read_o, wreg_o, instinvalid_o} = 4'b1110;
          end
          EXE_SLL, EXE_SRL, EXE_SRA: begin
            instinvalid_o = 1'b0;
            if (inst_i != '0) begin
              aop = r_aluop(fn);
              sel = EXE_RES_SHIFT;
              reg2_read_o = 1'b1;
              imm = {27'b0, inst_i[10:6]};
              wreg_o = 1'b1;
            end
          end
          EXE_SYNC: instinvalid_o = 1'b0;
          default: ;
        endcase
      EXE_ANDI, EXE_ORI, EXE_XORI: begin
        aop = op == EXE_ANDI ? EXE_AND_OP : op == EXE_ORI ? EXE_OR_OP : EXE_XOR_OP;
        sel = EXE_RES_LOGIC;
        imm = {16'b0, i16};
        {reg1_read_o, wreg_o, rt_dst, instinvalid_o} = 4'b1110;
      end
      EXE_LUI: begin
        aop = EXE_OR_OP;
        sel = EXE_RES_LOGIC;
        imm = {i16, 16'b0};
        {reg1_read_o, wreg_o, rt_dst, instinvalid_o} = 4'b1110;
      end
      EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_SLTIU: begin
        aop = op == EXE_ADDI ? EXE_ADDI_OP : op == EXE_ADDIU ? EXE_ADDIU_OP :
              op == EXE_SLTI ? EXE_SLT_OP : EXE_SLTU_OP;
        sel = EXE_RES_ARITH;
        imm = {{16{i16[15]}}, i16};
        {reg1_read_o, wreg_o, rt_dst, instinvalid_o} = 4'b1110;
      end
      EXE_LW: begin
        aop = EXE_LW_OP;
        sel = EXE_RES_LOAD_STORE;
        imm = {{16{i16[15]}}, i16};
        {reg1_read_o, wreg_o, rt_dst, is_load_o, instinvalid_o} = 5'b11110;
      end
      EXE_PREF: instinvalid_o = 1'b0;
      default: ;
    endcase
  end
endmodule

// File: rtl/id_stage_p.sv
// id_stage_p: decode stage with prioritised forwarding, load-use interlock and ID/EX register
module id_stage_p
  import id_stage_p_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                inst_i,
  output logic [REG_AW-1:0]          reg1_addr_o,
  output logic [REG_AW-1:0]          reg2_addr_o,
  output logic                       reg1_read_o,
  output logic                       reg2_read_o,
  input  logic [DATA_W-1:0]          reg1_data_i,
  input  logic [DATA_W-1:0]          reg2_data_i,
  input  logic [NUM_FWD-1:0]         fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0]  fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata_i,
  input  logic                       ex_load_i,
  input  logic                       flush_i,
  id_stage_p_if.master               ex,
  output logic                       stall_o
);
  typedef struct packed {
    logic                valid;
    logic [31:0]         pc;
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [DATA_W-1:0]   reg1;
    logic [DATA_W-1:0]   reg2;
    logic [REG_AW-1:0]   wd;
    logic                wreg;
    logic                is_load;
    logic                inv;
  } idex_t;
  logic [ALUOP_W-1:0]  aluop;
  logic [ALUSEL_W-1:0] alusel;
  logic [DATA_W-1:0]   imm, f1, f2, op1, op2;
  logic [REG_AW-1:0]   wd;
  logic                wreg, ld, inv, xfer, hz;
  logic [NUM_FWD-1:0]  h1, h2;
  logic [DATA_W-1:0]   fd [NUM_FWD];
  idex_t               idex_q, idex_d;
  id_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)) u_dec (
    .inst_i        (inst_i),
    .aluop_o       (aluop),
    .alusel_o      (alusel),
    .reg1_read_o   (reg1_read_o),
    .reg2_read_o   (reg2_read_o),
    .reg1_addr_o   (reg1_addr_o),
    .reg2_addr_o   (reg2_addr_o),
    .imm_o         (imm),
    .wd_o          (wd),
    .wreg_o        (wreg),
    .is_load_o     (ld),
    .instinvalid_o (inv)
  );
  for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
    assign fd[i] = fwd_wdata_i[i*DATA_W +: DATA_W];
    assign h1[i] = fwd_wreg_i[i] && fwd_wd_i[i*REG_AW +: REG_AW] == reg1_addr_o;
    assign h2[i] = fwd_wreg_i[i] && fwd_wd_i[i*REG_AW +: REG_AW] == reg2_addr_o;
  end
  // Walk sources from lowest priority up so the lowest-index match is applied last
  always_comb begin
    f1 = reg1_data_i;
    f2 = reg2_data_i;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      f1 = h1[j] ? fd[j] : f1;
      f2 = h2[j] ? fd[j] : f2;
    end
  end
  assign op1 = !reg1_read_o ? imm : reg1_addr_o == '0 ? '0 : f1;
  assign op2 = !reg2_read_o ? imm : reg2_addr_o == '0 ? '0 : f2;
  assign hz = (reg1_read_o && reg1_addr_o != '0 && reg1_addr_o == fwd_wd_i[REG_AW-1:0]) ||
              (reg2_read_o && reg2_addr_o != '0 && reg2_addr_o == fwd_wd_i[REG_AW-1:0]);
  assign stall_o = in_valid && ex_load_i && fwd_wreg_i[0] && hz;
  assign in_ready = !stall_o && (!idex_q.valid || ex.out_ready);
  assign xfer = in_valid && in_ready;
  // Next ID/EX contents: flush beats transfer, a consumed entry without refill becomes a bubble
  always_comb begin
    idex_d = idex_q;
    if (flush_i || (!xfer && ex.out_ready)) begin
      idex_d.valid = 1'b0;
      idex_d.wreg = 1'b0;
    end else if (xfer)
      idex_d = '{valid: 1'b1, pc: pc_i, aluop: aluop, alusel: alusel, reg1: op1, reg2: op2,
                 wd: wd, wreg: wreg, is_load: ld, inv: inv};
  end
  // ID/EX pipeline register with synchronous reset
  always_ff @(posedge clk)
    idex_q <= rst == RST_ACTIVE ? '0 : idex_d;
  assign ex.out_valid = idex_q.valid;
  assign ex.ex_pc = idex_q.pc;
  assign ex.ex_aluop = idex_q.aluop;
  assign ex.ex_alusel = idex_q.alusel;
  assign ex.ex_reg1 = idex_q.reg1;
  assign ex.ex_reg2 = idex_q.reg2;
  assign ex.ex_wd = idex_q.wd;
  assign ex.ex_wreg = idex_q.wreg;
  assign ex.ex_is_load = idex_q.is_load;
  assign ex.ex_instinvalid = idex_q.inv;
endmodule

// File: tb/tb_id_stage_p.sv
// tb_id_stage_p: directed checks of decode, forwarding, interlock and ID/EX handshake
module tb_id_stage_p;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, reg1_read, reg2_read, ex_load, flush, stall;
  logic [31:0] pc, inst, rd1, rd2;
  logic [4:0]  ra1, ra2;
  logic [1:0]  fwreg;
  logic [9:0]  fwd;
  logic [63:0] fwdata;
  int          n_chk = 0, n_fail = 0;
  id_stage_p_if #(.DATA_W(32), .REG_AW(5), .ALUOP_W(8), .ALUSEL_W(3)) ex_if ();
  id_stage_p #(.DATA_W(32), .REG_AW(5), .NUM_FWD(2), .ALUOP_W(8), .ALUSEL_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc), .inst_i(inst),
    .reg1_addr_o(ra1), .reg2_addr_o(ra2), .reg1_read_o(reg1_read), .reg2_read_o(reg2_read),
    .reg1_data_i(rd1), .reg2_data_i(rd2), .fwd_wreg_i(fwreg), .fwd_wd_i(fwd),
    .fwd_wdata_i(fwdata), .ex_load_i(ex_load), .flush_i(flush), .ex(ex_if), .stall_o(stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] p, input logic [31:0] w);
    in_valid = 1'b1;
    pc = p;
    inst = w;
  endtask
  initial begin
    rst = 1'b0; ex_if.out_ready = 1'b1; flush = 1'b0; ex_load = 1'b0;
    fwreg = 2'b00; fwd = '0; fwdata = '0; rd1 = 32'h1234; rd2 = 32'h5678;
    issue(32'h100, 32'h34018001);
    repeat (2) tick();
    chk("rst_valid", ex_if.out_valid, 0);
    chk("rst_pc", ex_if.ex_pc, 0);
    chk("rst_reg2", ex_if.ex_reg2, 0);
    chk("rst_wreg", ex_if.ex_wreg, 0);
    chk("rst_wd", ex_if.ex_wd, 0);
    chk("rst_aluop", ex_if.ex_aluop, 0);
    rst = 1'b1;
    #1;
    chk("ori_r1en", reg1_read, 1);
    chk("ori_r2en", reg2_read, 0);
    chk("ori_r1addr", ra1, 0);
    chk("ori_inready", in_ready, 1);
    chk("ori_stall", stall, 0);
    tick();
    chk("ori_reg1", ex_if.ex_reg1, 0);
    chk("ori_reg2", ex_if.ex_reg2, 32'h00008001);
    chk("ori_wd", ex_if.ex_wd, 1);
    chk("ori_wreg", ex_if.ex_wreg, 1);
    chk("ori_aluop", ex_if.ex_aluop, 32'h25);
    chk("ori_alusel", ex_if.ex_alusel, 1);
    chk("ori_valid", ex_if.out_valid, 1);
    chk("ori_pc", ex_if.ex_pc, 32'h100);
    chk("ori_inv", ex_if.ex_instinvalid, 0);
    issue(32'h104, 32'h20028001);
    tick();
    chk("addi_reg2", ex_if.ex_reg2, 32'hFFFF8001);
    chk("addi_wd", ex_if.ex_wd, 2);
    chk("addi_aluop", ex_if.ex_aluop, 32'h55);
    chk("addi_alusel", ex_if.ex_alusel, 4);
    rd1 = 32'h1111; rd2 = 32'h2222;
    fwreg = 2'b11; fwd = {5'd1, 5'd1}; fwdata = {32'h5555, 32'hAAAA};
    issue(32'h108, 32'h00221825);
    tick();
    chk("or_fwd0_reg1", ex_if.ex_reg1, 32'hAAAA);
    chk("or_rf_reg2", ex_if.ex_reg2, 32'h2222);
    chk("or_wd", ex_if.ex_wd, 3);
    fwreg = 2'b10;
    issue(32'h10C, 32'h00221825);
    tick();
    chk("or_fwd1_reg1", ex_if.ex_reg1, 32'h5555);
    fwreg = 2'b00;
    issue(32'h110, 32'h00221825);
    tick();
    chk("or_rf_reg1", ex_if.ex_reg1, 32'h1111);
    fwreg = 2'b01; fwd = {5'd0, 5'd0}; fwdata = {32'h0, 32'hDEAD};
    issue(32'h114, 32'h00002021);
    tick();
    chk("zero_reg1", ex_if.ex_reg1, 0);
    chk("zero_reg2", ex_if.ex_reg2, 0);
    chk("zero_wd", ex_if.ex_wd, 4);
    fwreg = 2'b00;
    issue(32'h118, 32'h000238C0);
    #1;
    chk("sll_r1en", reg1_read, 0);
    chk("sll_r2en", reg2_read, 1);
    chk("sll_r2addr", ra2, 2);
    tick();
    chk("sll_reg1", ex_if.ex_reg1, 3);
    chk("sll_reg2", ex_if.ex_reg2, 32'h2222);
    chk("sll_alusel", ex_if.ex_alusel, 2);
    chk("sll_aluop", ex_if.ex_aluop, 32'h7C);
    chk("sll_wd", ex_if.ex_wd, 7);
    issue(32'h11C, 32'h8C25FFFC);
    tick();
    chk("lw_reg1", ex_if.ex_reg1, 32'h1111);
    chk("lw_reg2", ex_if.ex_reg2, 32'hFFFFFFFC);
    chk("lw_isload", ex_if.ex_is_load, 1);
    chk("lw_wd", ex_if.ex_wd, 5);
    chk("lw_aluop", ex_if.ex_aluop, 32'hE3);
    chk("lw_alusel", ex_if.ex_alusel, 7);
    ex_load = 1'b1; fwreg = 2'b01; fwd = {5'd0, 5'd5}; fwdata = {32'h0, 32'h0BAD};
    issue(32'h120, 32'h00A53020);
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_inready", in_ready, 0);
    tick();
    chk("lu_bubble_valid", ex_if.out_valid, 0);
    chk("lu_bubble_wreg", ex_if.ex_wreg, 0);
    ex_load = 1'b0; fwreg = 2'b10; fwd = {5'd5, 5'd0}; fwdata = {32'h7777, 32'h0};
    #1;
    chk("lu2_stall", stall, 0);
    chk("lu2_inready", in_ready, 1);
    tick();
    chk("lu2_valid", ex_if.out_valid, 1);
    chk("lu2_reg1", ex_if.ex_reg1, 32'h7777);
    chk("lu2_reg2", ex_if.ex_reg2, 32'h7777);
    chk("lu2_wd", ex_if.ex_wd, 6);
    chk("lu2_pc", ex_if.ex_pc, 32'h120);
    chk("lu2_aluop", ex_if.ex_aluop, 32'h20);
    ex_if.out_ready = 1'b0; fwreg = 2'b00;
    issue(32'h200, 32'h34018001);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_inready", in_ready, 0);
      tick();
      chk("bp_valid", ex_if.out_valid, 1);
      chk("bp_pc", ex_if.ex_pc, 32'h120);
      chk("bp_reg1", ex_if.ex_reg1, 32'h7777);
      chk("bp_wd", ex_if.ex_wd, 6);
    end
    flush = 1'b1;
    tick();
    chk("fl_valid", ex_if.out_valid, 0);
    chk("fl_wreg", ex_if.ex_wreg, 0);
    chk("fl_pc_not_taken", ex_if.ex_pc, 32'h120);
    flush = 1'b0; ex_if.out_ready = 1'b1;
    tick();
    chk("post_fl_valid", ex_if.out_valid, 1);
    chk("post_fl_pc", ex_if.ex_pc, 32'h200);
    issue(32'h204, 32'hFC000000);
    tick();
    chk("inv_flag", ex_if.ex_instinvalid, 1);
    chk("inv_wreg", ex_if.ex_wreg, 0);
    chk("inv_valid", ex_if.out_valid, 1);
    issue(32'h208, 32'h00000000);
    tick();
    chk("nop_inv", ex_if.ex_instinvalid, 0);
    chk("nop_wreg", ex_if.ex_wreg, 0);
    issue(32'h20C, 32'h34018001);
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", ex_if.out_valid, 0);
    chk("mid_rst_pc", ex_if.ex_pc, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
